// File: rtl/rs_bank.sv
// rs_bank: multi-entry reservation station bank.
//   Holds up to ENTRIES dispatched ops, captures source operands from CDB_W
//   broadcast ways and issues up to ISSUE_W ready ops per cycle, oldest first.
//
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   defined   : an entry whose last missing operand matches the CDB this cycle
//               is ready this cycle; its issue operand comes straight from CDB_Data.
//   undefined : an entry becomes eligible the cycle after it captures the CDB value.
//
// Ports
//   clock, reset (async, active-low), flush (sync squash of all entries)
//   CDB_Data / CDB_PRF_idx / CDB_valid  : CDB_W broadcast ways
//   disp_*                              : DISP_W dispatch slots (operand holds a
//                                         PRF tag in its low bits when *_valid=0)
//   num_free, disp_overflow             : registered occupancy status
//   fu_ready / issue_*                  : ISSUE_W issue ports (combinational)
module rs_bank #(
  parameter int ENTRIES = 16,
  parameter int DISP_W  = 3,
  parameter int ISSUE_W = 3,
  parameter int CDB_W   = 3,
  parameter int XLEN    = 32,
  parameter int PRF_W   = 6,
  parameter int ROB_W   = 4,
  parameter int OLEN    = 16,
  parameter int PCLEN   = 32,
  parameter int FUNC_W  = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [CDB_W*XLEN-1:0]           CDB_Data,
  input  logic [CDB_W*PRF_W-1:0]          CDB_PRF_idx,
  input  logic [CDB_W-1:0]                CDB_valid,
  input  logic [DISP_W-1:0]               disp_valid,
  input  logic [DISP_W*XLEN-1:0]          disp_opa,
  input  logic [DISP_W*XLEN-1:0]          disp_opb,
  input  logic [DISP_W-1:0]               disp_opa_valid,
  input  logic [DISP_W-1:0]               disp_opb_valid,
  input  logic [DISP_W*PRF_W-1:0]         disp_dest_PRF_idx,
  input  logic [DISP_W*ROB_W-1:0]         disp_rob_idx,
  input  logic [DISP_W*OLEN-1:0]          disp_offset,
  input  logic [DISP_W*PCLEN-1:0]         disp_PC,
  input  logic [DISP_W*FUNC_W-1:0]        disp_Operation,
  input  logic [DISP_W-1:0]               disp_rd_mem,
  input  logic [DISP_W-1:0]               disp_wr_mem,
  output logic [$clog2(ENTRIES+1)-1:0]    num_free,
  output logic                            disp_overflow,
  input  logic [ISSUE_W-1:0]              fu_ready,
  output logic [ISSUE_W-1:0]              issue_valid,
  output logic [ISSUE_W*XLEN-1:0]         issue_opa,
  output logic [ISSUE_W*XLEN-1:0]         issue_opb,
  output logic [ISSUE_W*PRF_W-1:0]        issue_dest_PRF_idx,
  output logic [ISSUE_W*ROB_W-1:0]        issue_rob_idx,
  output logic [ISSUE_W*OLEN-1:0]         issue_offset,
  output logic [ISSUE_W*PCLEN-1:0]        issue_PC,
  output logic [ISSUE_W*FUNC_W-1:0]       issue_Operation,
  output logic [ISSUE_W-1:0]              issue_rd_mem,
  output logic [ISSUE_W-1:0]              issue_wr_mem
);
  localparam int CNT_W  = $clog2(ENTRIES+1);
  localparam int SLOT_W = (DISP_W > 1) ? $clog2(DISP_W) : 1;
  localparam logic [FUNC_W-1:0] ALU_ADD = '0;

  // Entry state
  logic [ENTRIES-1:0] occ_reg, opa_v_reg, opb_v_reg, rd_reg, wr_reg;
  logic [XLEN-1:0]    opa_reg  [ENTRIES];
  logic [XLEN-1:0]    opb_reg  [ENTRIES];
  logic [PRF_W-1:0]   dest_reg [ENTRIES];
  logic [ROB_W-1:0]   rob_reg  [ENTRIES];
  logic [OLEN-1:0]    off_reg  [ENTRIES];
  logic [PCLEN-1:0]   pc_reg   [ENTRIES];
  logic [FUNC_W-1:0]  op_reg   [ENTRIES];
  // older_reg[k][i] = 1 when entry k was dispatched before entry i
  logic [ENTRIES-1:0] older_reg [ENTRIES];

  // CDB match per stored operand; highest matching way wins
  logic [ENTRIES-1:0] a_hit, b_hit;
  logic [XLEN-1:0]    a_cdb [ENTRIES];
  logic [XLEN-1:0]    b_cdb [ENTRIES];
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      a_hit[i] = 1'b0; b_hit[i] = 1'b0; a_cdb[i] = '0; b_cdb[i] = '0;
      for (int w = 0; w < CDB_W; w++) begin
        if (CDB_valid[w] && CDB_PRF_idx[w*PRF_W +: PRF_W] == opa_reg[i][PRF_W-1:0]) begin
          a_hit[i] = 1'b1; a_cdb[i] = CDB_Data[w*XLEN +: XLEN];
        end
        if (CDB_valid[w] && CDB_PRF_idx[w*PRF_W +: PRF_W] == opb_reg[i][PRF_W-1:0]) begin
          b_hit[i] = 1'b1; b_cdb[i] = CDB_Data[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Readiness and the operand values presented on issue
  logic [ENTRIES-1:0] rdy;
  logic [XLEN-1:0]    iss_a [ENTRIES];
  logic [XLEN-1:0]    iss_b [ENTRIES];
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
      rdy[i]   = occ_reg[i] & (opa_v_reg[i] | a_hit[i]) & (opb_v_reg[i] | b_hit[i]);
      iss_a[i] = opa_v_reg[i] ? opa_reg[i] : a_cdb[i];
      iss_b[i] = opb_v_reg[i] ? opb_reg[i] : b_cdb[i];
`else
      rdy[i]   = occ_reg[i] & opa_v_reg[i] & opb_v_reg[i];
      iss_a[i] = opa_reg[i];
      iss_b[i] = opb_reg[i];
`endif
    end
  end

  // Rank of each ready entry = number of older ready entries (0 = oldest).
  // Port j serves rank == number of ready ports below j, so busy ports are skipped.
  logic [CNT_W-1:0] rank      [ENTRIES];
  logic [CNT_W-1:0] port_rank [ISSUE_W];
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      rank[i] = '0;
      for (int k = 0; k < ENTRIES; k++)
        if (rdy[k] && older_reg[k][i]) rank[i] = rank[i] + CNT_W'(1);
    end
    for (int j = 0; j < ISSUE_W; j++) begin
      port_rank[j] = '0;
      for (int p = 0; p < j; p++)
        if (fu_ready[p]) port_rank[j] = port_rank[j] + CNT_W'(1);
    end
  end

  logic [ENTRIES-1:0] fire;
  logic [CNT_W-1:0]   fire_cnt;
  always_comb begin
    issue_valid = '0; issue_opa = '0; issue_opb = '0; issue_dest_PRF_idx = '0;
    issue_rob_idx = '0; issue_offset = '0; issue_PC = '0; issue_Operation = '0;
    issue_rd_mem = '0; issue_wr_mem = '0; fire = '0; fire_cnt = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!flush && fu_ready[j] && rdy[i] && rank[i] == port_rank[j]) begin
          issue_valid[j]                         = 1'b1;
          fire[i]                                = 1'b1;
          issue_opa[j*XLEN +: XLEN]              = iss_a[i];
          issue_opb[j*XLEN +: XLEN]              = iss_b[i];
          issue_dest_PRF_idx[j*PRF_W +: PRF_W]   = dest_reg[i];
          issue_rob_idx[j*ROB_W +: ROB_W]        = rob_reg[i];
          issue_offset[j*OLEN +: OLEN]           = off_reg[i];
          issue_PC[j*PCLEN +: PCLEN]             = pc_reg[i];
          issue_Operation[j*FUNC_W +: FUNC_W]    = op_reg[i];
          issue_rd_mem[j]                        = rd_reg[i];
          issue_wr_mem[j]                        = wr_reg[i];
        end
      end
      if (issue_valid[j]) fire_cnt = fire_cnt + CNT_W'(1);
    end
  end

  // Allocation: valid slots in ascending order take the lowest free entries.
  // Entries that fire this cycle are still occupied here, so they are not reused.
  logic [ENTRIES-1:0] ent_alloc;
  logic [SLOT_W-1:0]  ent_slot [ENTRIES];
  logic [DISP_W-1:0]  drop;
  logic [CNT_W-1:0]   alloc_cnt;
  always_comb begin
    logic [ENTRIES-1:0] taken;
    logic               found;
    taken = occ_reg; ent_alloc = '0; drop = '0; alloc_cnt = '0; found = 1'b0;
    for (int e = 0; e < ENTRIES; e++) ent_slot[e] = '0;
    for (int s = 0; s < DISP_W; s++) begin
      found = 1'b0;
      if (disp_valid[s] && !flush) begin
        for (int e = 0; e < ENTRIES; e++) begin
          if (!found && !taken[e]) begin
            found = 1'b1; taken[e] = 1'b1; ent_alloc[e] = 1'b1; ent_slot[e] = SLOT_W'(s);
          end
        end
        if (found) alloc_cnt = alloc_cnt + CNT_W'(1);
        else       drop[s] = 1'b1;
      end
    end
  end

  // Dispatch-cycle capture: a tag operand already on the CDB enters as data
  logic [XLEN-1:0]   d_opa [DISP_W];
  logic [XLEN-1:0]   d_opb [DISP_W];
  logic [DISP_W-1:0] d_opa_v, d_opb_v;
  always_comb begin
    for (int s = 0; s < DISP_W; s++) begin
      d_opa[s] = disp_opa[s*XLEN +: XLEN]; d_opa_v[s] = disp_opa_valid[s];
      d_opb[s] = disp_opb[s*XLEN +: XLEN]; d_opb_v[s] = disp_opb_valid[s];
      for (int w = 0; w < CDB_W; w++) begin
        if (!disp_opa_valid[s] && CDB_valid[w] &&
            CDB_PRF_idx[w*PRF_W +: PRF_W] == disp_opa[s*XLEN +: PRF_W]) begin
          d_opa[s] = CDB_Data[w*XLEN +: XLEN]; d_opa_v[s] = 1'b1;
        end
        if (!disp_opb_valid[s] && CDB_valid[w] &&
            CDB_PRF_idx[w*PRF_W +: PRF_W] == disp_opb[s*XLEN +: PRF_W]) begin
          d_opb[s] = CDB_Data[w*XLEN +: XLEN]; d_opb_v[s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_reg <= '0; opa_v_reg <= '0; opb_v_reg <= '0; rd_reg <= '0; wr_reg <= '0;
      num_free <= CNT_W'(ENTRIES);
      disp_overflow <= 1'b0;
      for (int e = 0; e < ENTRIES; e++) begin
        opa_reg[e] <= '0; opb_reg[e] <= '0; dest_reg[e] <= '0; rob_reg[e] <= '0;
        off_reg[e] <= '0; pc_reg[e] <= '0; op_reg[e] <= ALU_ADD; older_reg[e] <= '0;
      end
    end else if (flush) begin
      occ_reg  <= '0;
      num_free <= CNT_W'(ENTRIES);
    end else begin
      num_free <= num_free - alloc_cnt + fire_cnt;
      if (|drop) disp_overflow <= 1'b1;
      for (int e = 0; e < ENTRIES; e++) begin
        if (ent_alloc[e]) begin
          occ_reg[e]   <= 1'b1;
          opa_reg[e]   <= d_opa[ent_slot[e]];
          opa_v_reg[e] <= d_opa_v[ent_slot[e]];
          opb_reg[e]   <= d_opb[ent_slot[e]];
          opb_v_reg[e] <= d_opb_v[ent_slot[e]];
          dest_reg[e]  <= disp_dest_PRF_idx[ent_slot[e]*PRF_W +: PRF_W];
          rob_reg[e]   <= disp_rob_idx[ent_slot[e]*ROB_W +: ROB_W];
          off_reg[e]   <= disp_offset[ent_slot[e]*OLEN +: OLEN];
          pc_reg[e]    <= disp_PC[ent_slot[e]*PCLEN +: PCLEN];
          op_reg[e]    <= disp_Operation[ent_slot[e]*FUNC_W +: FUNC_W];
          rd_reg[e]    <= disp_rd_mem[ent_slot[e]];
          wr_reg[e]    <= disp_wr_mem[ent_slot[e]];
          // New entry is younger than every occupied entry and than
          // entries taken by lower slots in this same cycle.
          for (int k = 0; k < ENTRIES; k++) begin
            if (k != e) begin
              older_reg[k][e] <= occ_reg[k] | (ent_alloc[k] & (ent_slot[k] < ent_slot[e]));
              older_reg[e][k] <= ~(occ_reg[k] | (ent_alloc[k] & (ent_slot[k] < ent_slot[e])));
            end
          end
        end else if (occ_reg[e]) begin
          if (fire[e]) occ_reg[e] <= 1'b0;
          if (!opa_v_reg[e] && a_hit[e]) begin
            opa_reg[e] <= a_cdb[e]; opa_v_reg[e] <= 1'b1;
          end
          if (!opb_v_reg[e] && b_hit[e]) begin
            opb_reg[e] <= b_cdb[e]; opb_v_reg[e] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_bank.sv
module tb_rs_bank;
  localparam int ENTRIES = 16, DISP_W = 3, ISSUE_W = 3, CDB_W = 3, XLEN = 32;
  localparam int PRF_W = 6, ROB_W = 4, OLEN = 16, PCLEN = 32, FUNC_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic [CDB_W*XLEN-1:0]    CDB_Data;
  logic [CDB_W*PRF_W-1:0]   CDB_PRF_idx;
  logic [CDB_W-1:0]         CDB_valid;
  logic [DISP_W-1:0]        disp_valid;
  logic [DISP_W*XLEN-1:0]   disp_opa, disp_opb;
  logic [DISP_W-1:0]        disp_opa_valid, disp_opb_valid;
  logic [DISP_W*PRF_W-1:0]  disp_dest_PRF_idx;
  logic [DISP_W*ROB_W-1:0]  disp_rob_idx;
  logic [DISP_W*OLEN-1:0]   disp_offset;
  logic [DISP_W*PCLEN-1:0]  disp_PC;
  logic [DISP_W*FUNC_W-1:0] disp_Operation;
  logic [DISP_W-1:0]        disp_rd_mem, disp_wr_mem;
  logic [4:0]               num_free;
  logic                     disp_overflow;
  logic [ISSUE_W-1:0]       fu_ready;
  logic [ISSUE_W-1:0]       issue_valid;
  logic [ISSUE_W*XLEN-1:0]  issue_opa, issue_opb;
  logic [ISSUE_W*PRF_W-1:0] issue_dest_PRF_idx;
  logic [ISSUE_W*ROB_W-1:0] issue_rob_idx;
  logic [ISSUE_W*OLEN-1:0]  issue_offset;
  logic [ISSUE_W*PCLEN-1:0] issue_PC;
  logic [ISSUE_W*FUNC_W-1:0] issue_Operation;
  logic [ISSUE_W-1:0]       issue_rd_mem, issue_wr_mem;

  int checks = 0;
  int errors = 0;

  rs_bank dut (
    .clock(clock), .reset(reset), .flush(flush),
    .CDB_Data(CDB_Data), .CDB_PRF_idx(CDB_PRF_idx), .CDB_valid(CDB_valid),
    .disp_valid(disp_valid), .disp_opa(disp_opa), .disp_opb(disp_opb),
    .disp_opa_valid(disp_opa_valid), .disp_opb_valid(disp_opb_valid),
    .disp_dest_PRF_idx(disp_dest_PRF_idx), .disp_rob_idx(disp_rob_idx),
    .disp_offset(disp_offset), .disp_PC(disp_PC), .disp_Operation(disp_Operation),
    .disp_rd_mem(disp_rd_mem), .disp_wr_mem(disp_wr_mem),
    .num_free(num_free), .disp_overflow(disp_overflow), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_opa(issue_opa), .issue_opb(issue_opb),
    .issue_dest_PRF_idx(issue_dest_PRF_idx), .issue_rob_idx(issue_rob_idx),
    .issue_offset(issue_offset), .issue_PC(issue_PC),
    .issue_Operation(issue_Operation), .issue_rd_mem(issue_rd_mem),
    .issue_wr_mem(issue_wr_mem)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    flush = 1'b0; CDB_valid = '0; CDB_Data = '0; CDB_PRF_idx = '0;
    disp_valid = '0; disp_opa = '0; disp_opb = '0; disp_opa_valid = '0; disp_opb_valid = '0;
    disp_dest_PRF_idx = '0; disp_rob_idx = '0; disp_offset = '0; disp_PC = '0;
    disp_Operation = '0; disp_rd_mem = '0; disp_wr_mem = '0;
  endtask

  task automatic slot(input int s, input logic [31:0] a, input logic av,
                      input logic [31:0] b, input logic bv, input logic [5:0] d,
                      input logic [4:0] op, input logic rd);
    disp_valid[s] = 1'b1;
    disp_opa[s*XLEN +: XLEN] = a; disp_opa_valid[s] = av;
    disp_opb[s*XLEN +: XLEN] = b; disp_opb_valid[s] = bv;
    disp_dest_PRF_idx[s*PRF_W +: PRF_W] = d;
    disp_rob_idx[s*ROB_W +: ROB_W] = d[3:0];
    disp_PC[s*PCLEN +: PCLEN] = {24'h0, d, 2'b00};
    disp_Operation[s*FUNC_W +: FUNC_W] = op;
    disp_rd_mem[s] = rd;
  endtask

  task automatic cdb(input int w, input logic [5:0] tag, input logic [31:0] data);
    CDB_valid[w] = 1'b1;
    CDB_PRF_idx[w*PRF_W +: PRF_W] = tag;
    CDB_Data[w*XLEN +: XLEN] = data;
  endtask

  function automatic logic [5:0] pdest(input int j);
    return issue_dest_PRF_idx[j*PRF_W +: PRF_W];
  endfunction

  function automatic logic [31:0] popa(input int j);
    return issue_opa[j*XLEN +: XLEN];
  endfunction

  initial begin
    clear_in();
    fu_ready = 3'b111;
    tick(); tick();
    settle();
    // reset state
    chk("rst_num_free", num_free, 16);
    chk("rst_overflow", disp_overflow, 0);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_op", issue_Operation, 0);
    chk("rst_issue_opa", issue_opa, 0);
    reset = 1'b1;
    tick();

    // 1: three ready ops issue next cycle in slot order
    clear_in();
    slot(0, 32'h100, 1, 32'h200, 1, 6'd1, 5'd0, 0);
    slot(1, 32'h101, 1, 32'h201, 1, 6'd2, 5'd3, 0);
    slot(2, 32'h102, 1, 32'h202, 1, 6'd3, 5'd0, 1);
    settle();
    chk("t1_disp_cycle_free", num_free, 16);
    chk("t1_disp_cycle_iv", issue_valid, 0);
    tick(); clear_in(); settle();
    chk("t1_iv", issue_valid, 3'b111);
    chk("t1_dest0", pdest(0), 1);
    chk("t1_dest1", pdest(1), 2);
    chk("t1_dest2", pdest(2), 3);
    chk("t1_opa0", popa(0), 32'h100);
    chk("t1_op1", issue_Operation[FUNC_W +: FUNC_W], 3);
    chk("t1_rd2", issue_rd_mem, 3'b100);
    chk("t1_free_mid", num_free, 13);
    tick(); settle();
    chk("t1_free_end", num_free, 16);
    chk("t1_iv_end", issue_valid, 0);

    // 2: wakeup via CDB way1 two cycles after dispatch
    clear_in();
    slot(0, 32'd5, 0, 32'h11, 1, 6'd10, 5'd0, 0);
    tick(); clear_in(); settle();
    chk("t2_wait_iv", issue_valid, 0);
    tick(); cdb(1, 6'd5, 32'hDEAD); settle();
`ifdef RS_WAKEUP_BYPASS_EN
    chk("t2_byp_iv", issue_valid, 3'b001);
    chk("t2_byp_opa", popa(0), 32'hDEAD);
    chk("t2_byp_dest", pdest(0), 10);
    tick(); clear_in(); settle();
    chk("t2_after_iv", issue_valid, 0);
`else
    chk("t2_cap_iv", issue_valid, 0);
    tick(); clear_in(); settle();
    chk("t2_iv", issue_valid, 3'b001);
    chk("t2_opa", popa(0), 32'hDEAD);
    chk("t2_dest", pdest(0), 10);
    tick(); settle();
    chk("t2_after_iv", issue_valid, 0);
`endif

    // 3: operand tag broadcast in the dispatch cycle is not lost
    clear_in();
    slot(0, 32'd7, 0, 32'h22, 1, 6'd20, 5'd0, 0);
    cdb(0, 6'd7, 32'hBEEF);
    settle();
    chk("t3_disp_iv", issue_valid, 0);
    tick(); clear_in(); settle();
    chk("t3_iv", issue_valid, 3'b001);
    chk("t3_opa", popa(0), 32'hBEEF);
    chk("t3_opb", issue_opb[31:0], 32'h22);
    chk("t3_dest", pdest(0), 20);
    tick(); settle();
    chk("t3_free", num_free, 16);

    // 4: fill all entries, then overflow
    fu_ready = 3'b000;
    for (int c = 0; c < 6; c++) begin
      clear_in();
      for (int s = 0; s < 3; s++) begin
        if (3*c + s < 16)
          slot(s, 32'(3*c + s), 1, 32'h0, 1, 6'(32 + 3*c + s), 5'd0, 0);
      end
      tick();
    end
    clear_in(); settle();
    chk("t4_full_free", num_free, 0);
    chk("t4_full_ovf", disp_overflow, 0);
    slot(0, 32'hBAD0, 1, 32'h0, 1, 6'd60, 5'd0, 0);
    slot(1, 32'hBAD1, 1, 32'h0, 1, 6'd61, 5'd0, 0);
    tick(); clear_in(); settle();
    chk("t4_ovf", disp_overflow, 1);
    chk("t4_ovf_free", num_free, 0);
    fu_ready = 3'b111;
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("t4_drain_iv", issue_valid, (c < 5) ? 3'b111 : 3'b001);
      for (int j = 0; j < 3; j++) begin
        if (3*c + j < 16) begin
          chk("t4_drain_dest", pdest(j), 64'(32 + 3*c + j));
          chk("t4_drain_opa", popa(j), 64'(3*c + j));
        end
      end
      tick();
    end
    settle();
    chk("t4_empty_free", num_free, 16);
    chk("t4_ovf_sticky", disp_overflow, 1);
    chk("t4_empty_iv", issue_valid, 0);

    // 5: age beats index; busy ports are skipped
    fu_ready = 3'b000;
    clear_in();
    slot(0, 32'h1, 1, 32'h1, 1, 6'd3, 5'd0, 0);   // F -> entry 0
    tick(); clear_in();
    slot(0, 32'hA, 1, 32'h1, 1, 6'd1, 5'd0, 0);   // A -> entry 1
    fu_ready = 3'b001;
    settle();
    chk("t5_f_iv", issue_valid, 3'b001);
    chk("t5_f_dest", pdest(0), 3);
    tick(); clear_in();
    slot(0, 32'hB, 1, 32'h1, 1, 6'd2, 5'd0, 0);   // B -> entry 0, younger
    fu_ready = 3'b000;
    settle();
    chk("t5_hold_iv", issue_valid, 0);
    tick(); clear_in();
    fu_ready = 3'b010;
    settle();
    chk("t5_a_iv", issue_valid, 3'b010);
    chk("t5_a_dest", pdest(1), 1);
    tick(); settle();
    chk("t5_b_iv", issue_valid, 3'b010);
    chk("t5_b_dest", pdest(1), 2);
    tick(); settle();
    chk("t5_done_iv", issue_valid, 0);
    chk("t5_free", num_free, 16);

    // 6: flush with 10 occupied entries plus concurrent dispatch
    fu_ready = 3'b000;
    for (int c = 0; c < 4; c++) begin
      clear_in();
      for (int s = 0; s < 3; s++) begin
        if (3*c + s < 10)
          slot(s, 32'h5, 1, 32'h6, 1, 6'(40 + 3*c + s), 5'd0, 0);
      end
      tick();
    end
    clear_in(); settle();
    chk("t6_pre_free", num_free, 6);
    flush = 1'b1;
    fu_ready = 3'b111;
    slot(0, 32'h7, 1, 32'h7, 1, 6'd50, 5'd0, 0);
    slot(1, 32'h7, 1, 32'h7, 1, 6'd51, 5'd0, 0);
    slot(2, 32'h7, 1, 32'h7, 1, 6'd52, 5'd0, 0);
    settle();
    chk("t6_flush_iv", issue_valid, 0);
    tick(); clear_in(); settle();
    chk("t6_post_free", num_free, 16);
    chk("t6_post_iv", issue_valid, 0);
    chk("t6_post_ovf", disp_overflow, 1);
    tick(); settle();
    chk("t6_post2_iv", issue_valid, 0);

    // reset asserted while a wakeup is in flight
    slot(0, 32'd12, 0, 32'h1, 1, 6'd55, 5'd0, 0);
    tick(); clear_in();
    cdb(2, 6'd12, 32'h1234);
    settle();
    reset = 1'b0;
    #1;
    chk("t6_rst_free", num_free, 16);
    chk("t6_rst_ovf", disp_overflow, 0);
    chk("t6_rst_iv", issue_valid, 0);
    tick();
    reset = 1'b1;
    clear_in(); settle();
    chk("t6_rel_iv", issue_valid, 0);
    chk("t6_rel_free", num_free, 16);
    tick(); settle();
    chk("t6_rel2_iv", issue_valid, 0);

    // fresh dispatch after reset works normally
    slot(0, 32'h99, 1, 32'h1, 1, 6'd9, 5'd0, 0);
    tick(); clear_in(); settle();
    chk("t6_new_iv", issue_valid, 3'b001);
    chk("t6_new_dest", pdest(0), 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
